// File: rtl/reg_bank_sb.sv
// rtl/reg_bank_sb.sv - parametrised register bank with pending-write scoreboard (optional REGBANK_BYPASS_EN)
module reg_bank_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] r_reg1,
  input  logic [ADDR_W-1:0] r_reg2,
  output logic [DATA_W-1:0] r_data1,
  output logic [DATA_W-1:0] r_data2,
  output logic              r_busy1,
  output logic              r_busy2,
  output logic              issue_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] bank [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pend_nxt;

  logic              wr_hit;
  logic              issue_hit;
  logic              conflict_nxt;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic              rd1_busy;
  logic              rd2_busy;

  assign wr_hit       = wr_en && (wr_reg != '0);
  assign issue_hit    = issue_en && (issue_reg != '0);
  assign conflict_nxt = issue_hit && pending[issue_reg];

  // Next-state scoreboard: clear on writeback, then set on issue so a new producer wins
  always_comb begin
    pend_nxt = pending;
    if (wr_hit) begin
      pend_nxt[wr_reg] = 1'b0;
    end
    if (issue_hit) begin
      pend_nxt[issue_reg] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Read port 1 value and busy flag, including same-cycle write handling
  always_comb begin
    rd1_data = bank[r_reg1];
    rd1_busy = pend_nxt[r_reg1];
`ifdef REGBANK_BYPASS_EN
    if (wr_hit && (wr_reg == r_reg1)) begin
      rd1_data = wr_data;
    end
`else
    // Data being written this cycle is not visible yet, so flag it as not ready
    if (wr_hit && (wr_reg == r_reg1)) begin
      rd1_busy = 1'b1;
    end
`endif
    if (r_reg1 == '0) begin
      rd1_data = '0;
      rd1_busy = 1'b0;
    end
  end

  // Read port 2 value and busy flag, same rules as port 1
  always_comb begin
    rd2_data = bank[r_reg2];
    rd2_busy = pend_nxt[r_reg2];
`ifdef REGBANK_BYPASS_EN
    if (wr_hit && (wr_reg == r_reg2)) begin
      rd2_data = wr_data;
    end
`else
    if (wr_hit && (wr_reg == r_reg2)) begin
      rd2_busy = 1'b1;
    end
`endif
    if (r_reg2 == '0) begin
      rd2_data = '0;
      rd2_busy = 1'b0;
    end
  end

  // Register bank storage; entry 0 is never written and stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else if (wr_hit) begin
      bank[wr_reg] <= wr_data;
    end
  end

  // Scoreboard state, conflict pulse and registered read outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= '0;
      issue_conflict <= 1'b0;
      r_data1        <= '0;
      r_data2        <= '0;
      r_busy1        <= 1'b0;
      r_busy2        <= 1'b0;
    end else begin
      pending        <= pend_nxt;
      issue_conflict <= conflict_nxt;
      r_data1        <= rd1_data;
      r_data2        <= rd2_data;
      r_busy1        <= rd1_busy;
      r_busy2        <= rd2_busy;
    end
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb/tb_reg_bank_sb.sv - table-driven self-checking bench for reg_bank_sb
module tb_reg_bank_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [15:0] wr_data;
  logic        issue_en;
  logic [2:0]  issue_reg;
  logic [2:0]  r_reg1;
  logic [2:0]  r_reg2;
  logic [15:0] r_data1;
  logic [15:0] r_data2;
  logic        r_busy1;
  logic        r_busy2;
  logic        issue_conflict;

  reg_bank_sb #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_reg         (wr_reg),
    .wr_data        (wr_data),
    .issue_en       (issue_en),
    .issue_reg      (issue_reg),
    .r_reg1         (r_reg1),
    .r_reg2         (r_reg2),
    .r_data1        (r_data1),
    .r_data2        (r_data2),
    .r_busy1        (r_busy1),
    .r_busy2        (r_busy2),
    .issue_conflict (issue_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        ie;
    logic [2:0]  ireg;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic        e_ic;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void add(input logic r, input logic we, input logic [2:0] wreg,
                              input logic [15:0] wdata, input logic ie, input logic [2:0] ireg,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic [15:0] d1, input logic [15:0] d2,
                              input logic b1, input logic b2, input logic ic);
    vec_t v;
    v.rst = r; v.we = we; v.wreg = wreg; v.wdata = wdata; v.ie = ie; v.ireg = ireg;
    v.ra = ra; v.rb = rb; v.e_d1 = d1; v.e_d2 = d2; v.e_b1 = b1; v.e_b2 = b2; v.e_ic = ic;
    vecs.push_back(v);
  endfunction

  task automatic apply(input logic r, input logic we, input logic [2:0] wreg,
                       input logic [15:0] wdata, input logic ie, input logic [2:0] ireg,
                       input logic [2:0] ra, input logic [2:0] rb);
    rst = r; wr_en = we; wr_reg = wreg; wr_data = wdata;
    issue_en = ie; issue_reg = ireg; r_reg1 = ra; r_reg2 = rb;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] d1, input logic [15:0] d2,
                       input logic b1, input logic b2, input logic ic);
    n_vec++;
    if (r_data1 !== d1 || r_data2 !== d2 || r_busy1 !== b1 || r_busy2 !== b2 ||
        issue_conflict !== ic) begin
      n_fail++;
      $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b ic=%b, want d1=%h d2=%h b1=%b b2=%b ic=%b",
               name, r_data1, r_data2, r_busy1, r_busy2, issue_conflict, d1, d2, b1, b2, ic);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_reg = '0; wr_data = '0;
    issue_en = 1'b0; issue_reg = '0; r_reg1 = '0; r_reg2 = '0;

    //  rst we wreg wdata     ie ireg ra rb   d1        d2        b1 b2 ic
    // reset, then read every address
    add(1, 0, 0, 16'h0000, 1, 5, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 1,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 2, 3,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 4, 5,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 6, 7,  16'h0000, 16'h0000, 0, 0, 0);
    // write r3, write r0 (ignored), read back
    add(0, 1, 3, 16'hBEEF, 0, 0, 1, 2,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 16'h1234, 0, 0, 3, 0,  16'hBEEF, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 3,  16'h0000, 16'hBEEF, 0, 0, 0);
    // scoreboard lifecycle on r5; busy shows this cycle's set
    add(0, 0, 0, 16'h0000, 1, 5, 5, 5,  16'h0000, 16'h0000, 1, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 5, 0,  16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 5, 16'hA5A5, 0, 0, 4, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 5, 5,  16'hA5A5, 16'hA5A5, 0, 0, 0);
    // top address is valid
    add(0, 1, 7, 16'h7777, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 7, 3,  16'h7777, 16'hBEEF, 0, 0, 0);
    // same-cycle write and read of pending r2
    add(0, 1, 2, 16'h0011, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 1, 2, 3, 2,  16'hBEEF, 16'h0011, 0, 1, 0);
`ifdef REGBANK_BYPASS_EN
    add(0, 1, 2, 16'h0022, 0, 0, 2, 2,  16'h0022, 16'h0022, 0, 0, 0);
`else
    add(0, 1, 2, 16'h0022, 0, 0, 2, 2,  16'h0011, 16'h0011, 1, 1, 0);
`endif
    add(0, 0, 0, 16'h0000, 0, 0, 2, 1,  16'h0022, 16'h0000, 0, 0, 0);
    // simultaneous issue and writeback to r6: set wins; second issue conflicts once
    add(0, 1, 6, 16'h6666, 1, 6, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 6, 6,  16'h6666, 16'h6666, 1, 1, 0);
    add(0, 0, 0, 16'h0000, 1, 6, 1, 1,  16'h0000, 16'h0000, 0, 0, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 6, 0,  16'h6666, 16'h0000, 1, 0, 0);
    // reset mid-operation, reset overrides a concurrent write and issue
    add(0, 0, 0, 16'h0000, 1, 1, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 1, 4, 1, 0,  16'h0000, 16'h0000, 1, 0, 0);
    add(1, 1, 7, 16'hFFFF, 1, 3, 1, 4,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 1, 4,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 3, 7,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 1, 4, 16'h0F0F, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 4, 5,  16'h0F0F, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 6, 2,  16'h0000, 16'h0000, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].we, vecs[i].wreg, vecs[i].wdata,
            vecs[i].ie, vecs[i].ireg, vecs[i].ra, vecs[i].rb);
      check($sformatf("vec%0d", i), vecs[i].e_d1, vecs[i].e_d2,
            vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_ic);
    end

    // back-to-back issues to r2: conflict asserted only for the repeated issue
    apply(0, 0, 0, 16'h0000, 1, 2, 2, 0);
    check("seq_issue_first", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    apply(0, 0, 0, 16'h0000, 1, 2, 0, 2);
    check("seq_issue_again", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    apply(0, 0, 0, 16'h0000, 0, 0, 2, 2);
    check("seq_conflict_drop", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    // outputs hold until the next edge even when inputs change
    r_reg1 = 3'd4; r_reg2 = 3'd0;
    #3;
    check("seq_hold", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("seq_after_hold", 16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b0);
    // writeback of a pending register clears busy
    apply(0, 1, 2, 16'hC0DE, 0, 0, 0, 0);
    check("seq_wb", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    apply(0, 0, 0, 16'h0000, 0, 0, 2, 4);
    check("seq_wb_read", 16'hC0DE, 16'h0F0F, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
- Parametrised successor to the 8x16 register bank for the pipelined datapath.
- Width and depth are configurable. Two registered read ports and one write port.
- Register 0 is hardwired to zero.
- Adds a per-register pending-write scoreboard: decode marks a destination busy at issue, and writeback clears it. Read ports return data plus a busy flag so hazard logic can stall.

Parameters:
DATA_W, 16, width of each register and data port
ADDR_W, 3, register address width; depth = 2**ADDR_W

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  writeback strobe
wr_reg  input  ADDR_W  writeback destination register
wr_data  input  DATA_W  writeback data
issue_en  input  1  instruction issue strobe; marks issue_reg pending
issue_reg  input  ADDR_W  destination of issuing instruction
r_reg1  input  ADDR_W  read port 1 address
r_reg2  input  ADDR_W  read port 2 address
r_data1  output  DATA_W  read port 1 data, registered
r_data2  output  DATA_W  read port 2 data, registered
r_busy1  output  1  register on port 1 has an outstanding write, registered
r_busy2  output  1  register on port 2 has an outstanding write, registered
issue_conflict  output  1  one-cycle pulse: issue targeted an already-pending register

Behaviour:
- Reset (rst=1 at posedge): all registers = 0; all pending bits = 0; r_data1/2 = 0; r_busy1/2 = 0; issue_conflict = 0. Reset overrides every other input in the same cycle.
- Reset mid-operation: in-flight pending bits are discarded. A writeback arriving after reset writes normally and leaves its pending bit at 0.
- Write:
  - wr_en=1 and wr_reg!=0: bank[wr_reg] <= wr_data at the edge.
  - wr_reg==0: ignored, no state change.
- Read, 1-cycle latency: addresses sampled at edge N; r_dataN and r_busyN are valid after edge N and hold until the next edge.
  - r_regN==0 always returns 0 and busy 0.
  - Otherwise returns bank[r_regN], subject to the bypass rule under Optional Feature.
- Scoreboard: one pending bit per register; bit 0 is constant 0.
  - Set: issue_en=1 and issue_reg!=0.
  - Clear: wr_en=1 and wr_reg matches, wr_reg!=0.
  - Same register set and cleared in one cycle: set wins, because the new producer supersedes the retiring one.
  - Issue to an already-set bit: bit stays set; issue_conflict=1 next cycle. Otherwise issue_conflict=0.
  - Writeback to a non-pending register: legal; data is written, bit stays 0.
- Busy output: r_busyN <= next-state pending[r_regN], i.e. it includes this cycle's set and clear. See Optional Feature for the non-bypass rule.
- Both ports are independent. Identical addresses on both ports give identical results.
- Wrap-around: none. Addresses are full-range and every value 0..2**ADDR_W-1 is valid.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding on both ports. If wr_en=1, wr_reg!=0 and wr_reg==r_regN, then r_dataN <= wr_data.
  - Busy follows the scoreboard rule above, so a retiring write reads as not busy with fresh data.
- Undefined:
  - No forwarding; r_dataN <= pre-write bank contents.
  - r_busyN is additionally forced to 1 when wr_en=1, wr_reg!=0 and wr_reg==r_regN. Consumers therefore never see stale data flagged as ready.
  - Data becomes visible with busy 0 on the following read.

Test Plan:
- Reset then read all addresses: assert rst 1 cycle, read regs 0..7 -> every r_data=0x0000, r_busy=0, issue_conflict=0.
- Write/read and R0: write 0xBEEF to r3, write 0x1234 to r0; next cycle read r_reg1=3, r_reg2=0 -> r_data1=0xBEEF, r_data2=0x0000, both busy 0.
- Scoreboard lifecycle: issue r5; next cycle read r5 -> r_busy1=1. Later write 0xA5A5 to r5, read r5 the following cycle -> r_data1=0xA5A5, r_busy1=0.
- Same-cycle write+read of r2 (r2 was 0x0011, writing 0x0022, pending):
  - Bypass on -> r_data=0x0022, busy 0.
  - Bypass off -> r_data=0x0011, busy 1; next cycle 0x0022, busy 0.
- Simultaneous issue and writeback to r6 -> r6 data updated, pending stays 1 (r_busy=1). Second issue to r6 -> issue_conflict=1 for exactly one cycle.
- Reset mid-operation: issue r1, r4, assert rst, then read r1/r4 -> data 0, busy 0. Subsequent writeback to r4 of 0x0F0F -> r_data=0x0F0F, busy 0.
